// File: rtl/fsm_arb_pkg.sv
// Shared types and defaults for the FSM job arbiter.
// The optional WAIT timeout is enabled by defining FSM_ARB_TIMEOUT_EN.
package fsm_arb_pkg;

   localparam int FSM_ARB_DATA_W      = 16;
   localparam int FSM_ARB_TIMEOUT_DEF = 1024;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BLANK = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } fsm_arb_state_t;

endpackage

// File: rtl/fsm_arb_rr_pick.sv
// Combinational rotate-priority picker: first set req_valid bit at or above ptr, with wrap.
module fsm_arb_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] win,
   output logic [IW-1:0]    win_idx,
   output logic             win_any
);

   int j;

   // Scan from farthest to nearest so the candidate closest to ptr is written last.
   always_comb begin
      win     = '0;
      win_idx = '0;
      win_any = 1'b0;
      j       = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N_REQ;
         if (req_valid[j]) begin
            win     = '0;
            win[j]  = 1'b1;
            win_idx = IW'(j);
            win_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fsm_job_arbiter.sv
// Round-robin front end sharing one FSM compute engine among N_REQ requesters.
// Define FSM_ARB_TIMEOUT_EN to bound WAIT at TIMEOUT_CYC cycles (resp_err=1 on expiry).
module fsm_job_arbiter
   import fsm_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = FSM_ARB_DATA_W,
   parameter int TIMEOUT_CYC = FSM_ARB_TIMEOUT_DEF,
   localparam int IW         = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        resp_valid,
   output logic                    resp_err,
   output logic                    eng_start,
   output logic [DATA_W-1:0]       eng_d,
   input  logic                    eng_done,
   output logic                    busy,
   output logic [IW-1:0]           grant_id
);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("fsm_job_arbiter: unsupported N_REQ/TIMEOUT_CYC");
   end

   fsm_arb_state_t    state_q, state_d;
   logic [IW-1:0]     ptr_q, grant_q;
   logic [DATA_W-1:0] data_q;
   logic [N_REQ-1:0]  win;
   logic [IW-1:0]     win_idx;
   logic              win_any;
   logic              tmo_hit;

   fsm_arb_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .win       (win),
      .win_idx   (win_idx),
      .win_any   (win_any)
   );

`ifdef FSM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC);
   logic [CW-1:0] cnt_q;
   logic          err_q;

   // Done in the final WAIT cycle takes priority over the timeout.
   assign tmo_hit  = (state_q == ST_WAIT) && !eng_done && (cnt_q == CW'(TIMEOUT_CYC - 1));
   assign resp_err = (state_q == ST_RESP) && err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == ST_BLANK)     cnt_q <= '0;
         else if (state_q == ST_WAIT) cnt_q <= cnt_q + CW'(1);
         if (state_q == ST_WAIT) begin
            if (eng_done)     err_q <= 1'b0;
            else if (tmo_hit) err_q <= 1'b1;
         end
      end
   end
`else
   assign tmo_hit  = 1'b0;
   assign resp_err = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      resp_valid = '0;
      eng_start  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = win;
            if (win_any) state_d = ST_START;
         end
         ST_START: begin
            eng_start = 1'b1;
            state_d   = ST_BLANK;
         end
         // eng_done may still be high from the previous job here.
         ST_BLANK: state_d = ST_WAIT;
         ST_WAIT: begin
            if (eng_done || tmo_hit) state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_valid[grant_q] = 1'b1;
            state_d             = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy     = (state_q != ST_IDLE);
   assign eng_d    = data_q;
   assign grant_id = grant_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && win_any) begin
            grant_q <= win_idx;
            data_q  <= req_data[win_idx*DATA_W +: DATA_W];
         end
         if (state_q == ST_RESP)
            ptr_q <= (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);
      end
   end

endmodule

// File: doc/fsm_job_arbiter.md
# fsm_job_arbiter

Shares the single 16-bit `FSM` compute engine among `N_REQ` requesters. Accepts one job at a time by round-robin arbitration and latches its operand. It sequences the engine's `start`/`d`/`done` handshake and returns a one-cycle completion pulse to the owning requester. The block sits between the requester-side logic and one `FSM` instance, and is the only driver of that instance's `start` and `d`.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 16, operand width; matches the engine `d` input
- `TIMEOUT_CYC`, 1024, maximum wait for `eng_done` (used only with the timeout feature)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  N_REQ  per-requester job request
- `req_data`  in  N_REQ*DATA_W  operands; requester i occupies bits [i*DATA_W +: DATA_W]
- `req_ready`  out  N_REQ  one-hot acceptance; a job transfers when `req_valid[i] & req_ready[i]`
- `resp_valid`  out  N_REQ  one-cycle completion pulse to the job owner
- `resp_err`  out  1  qualifies `resp_valid`; 1 means timeout
- `eng_start`  out  1  engine start
- `eng_d`  out  DATA_W  engine operand
- `eng_done`  in  1  engine completion; level signal, may stay high until the next start
- `busy`  out  1  high in every state except IDLE
- `grant_id`  out  $clog2(N_REQ)  index of the current or last owner

## Operation
- States: IDLE, START, BLANK, WAIT, RESP.
- IDLE:
  - Winner is the first set `req_valid` bit, searched from `ptr` upward with wrap.
  - `req_ready[winner]` is asserted combinationally.
  - On transfer: latch `req_data[winner]` into `eng_d`, latch the winner into `grant_id`, go to START.
  - With no `req_valid` set, stay in IDLE.
- START: `eng_start`=1 for exactly one cycle, then go to BLANK.
- BLANK: `eng_done` is ignored, because it may be stale-high from the previous job. Go to WAIT.
- WAIT: `eng_done`=1 → RESP with err=0. Otherwise stay in WAIT, or time out (see Configuration).
- RESP:
  - `resp_valid[grant_id]`=1 and `resp_err`=err for one cycle.
  - `ptr` ← (`grant_id`+1) mod N_REQ; N_REQ-1 wraps to 0.
  - Go to IDLE.
- `eng_d` holds from the transfer cycle until the next transfer.
- `req_ready` is 0 in every state except IDLE. A requester holding `req_valid` while busy waits.
- `eng_done` is ignored in IDLE, START and BLANK.
- A requester that drops `req_valid` before acceptance is simply not selected.

## Timing
- Reset values: state=IDLE, `ptr`=0, `grant_id`=0, `eng_d`=0, all other outputs 0, timeout counter=0.
- `reset` asserted mid-job forces IDLE immediately and drops `eng_start` asynchronously. No response is issued for the aborted job.
- Cycle sequence:
  - Transfer at cycle T.
  - `eng_start` high in T+1.
  - BLANK in T+2.
  - WAIT from T+3.
  - `eng_done` sampled high at cycle D ≥ T+3 → `resp_valid` in D+1.
  - IDLE in D+2; the next transfer can occur at D+2.
- Minimum transfer-to-response latency: 4 cycles.
- Simultaneous requests: exactly one `req_ready` bit is high, chosen by `ptr` order.

## Configuration
- `FSM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYC-1 with `eng_done` low, go to RESP with err=1.
  - If `eng_done`=1 in that same final cycle, done wins and err=0.
- `FSM_ARB_TIMEOUT_EN` undefined:
  - WAIT lasts indefinitely.
  - The counter is not built.
  - `resp_err` is tied to 0.

## Structure
- `fsm_arb_pkg` holds:
  - the state enum `fsm_arb_state_t`
  - default constants `FSM_ARB_DATA_W`=16 and `FSM_ARB_TIMEOUT_DEF`=1024
- Sub-module `fsm_arb_rr_pick`: combinational rotate-priority picker, taking `req_valid` and `ptr` and producing a one-hot winner and its index. The arbiter holds all state.

## Test plan
- Single job: `req_valid[2]`=1, `req_data[2]`=16'h7F80, `eng_done` rises 5 cycles after `eng_start` → `eng_d`=16'h7F80, one `eng_start` pulse, `resp_valid`=4'b0100, `resp_err`=0, back in IDLE.
- Contention after reset: all four requesters valid continuously, engine done 3 cycles after start → grant order 0,1,2,3,0.
- Stale done: `eng_done` held high from the previous job through START/BLANK → it is not accepted as completion before WAIT. `resp_valid` appears no earlier than T+4.
- Reset mid-WAIT: assert `reset` 2 cycles into WAIT → `eng_start`=0, `busy`=0, no `resp_valid`, `ptr`=0.
- Timeout (macro on, TIMEOUT_CYC=8): `eng_done` never rises → `resp_valid` with `resp_err`=1 exactly 8 WAIT cycles after entry. With `eng_done`=1 on the 8th WAIT cycle → `resp_err`=0.
- Wrap: last grant to requester 3, requesters 0 and 3 valid → requester 0 granted.
